// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter
//
// Pipelined barrel shifter for the EX stage. Supports SLL, SRL, SRA, ROL and
// ROR. The shift is decomposed into SHAMT_W binary levels (level k shifts by
// 2^k), and those levels are spread across PIPE_STAGES register stages. Each
// stage carries its valid bit, the partially shifted data, the shift amount,
// the op code and the tag. The result appears PIPE_STAGES cycles after
// acceptance when the pipeline is not stalled.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous squash of every in-flight operation
//   in_valid   input operation valid
//   in_ready   block accepts an operation this cycle
//   in_data    operand
//   in_shamt   shift amount, 0..DATA_W-1
//   in_op      op code: 1x0/1x1 rotate (bit1 = right), 011 SRA, 010 SRL, 00x SLL
//   in_tag     sideband carried unmodified
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   shift result
//   out_tag    sideband belonging to the result
module pipe_barrel_shifter #(
   parameter int DATA_W      = 32,
   parameter int SHAMT_W     = $clog2(DATA_W),
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [2:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int LAST = PIPE_STAGES - 1;

   logic [PIPE_STAGES-1:0] stage_valid;
   logic [PIPE_STAGES-1:0] stage_move;
   logic [PIPE_STAGES-1:0] stage_free;
   logic [PIPE_STAGES-1:0] load_valid;

   logic [DATA_W-1:0]  stage_data  [PIPE_STAGES];
   logic [SHAMT_W-1:0] stage_shamt [PIPE_STAGES];
   logic [2:0]         stage_op    [PIPE_STAGES];
   logic [TAG_W-1:0]   stage_tag   [PIPE_STAGES];

   logic [DATA_W-1:0]  next_data  [PIPE_STAGES];
   logic [SHAMT_W-1:0] next_shamt [PIPE_STAGES];
   logic [2:0]         next_op    [PIPE_STAGES];
   logic [TAG_W-1:0]   next_tag   [PIPE_STAGES];

   // One binary level of the shifter. n is always a power of two below
   // DATA_W, so the wrap-around term of the rotates never shifts by DATA_W.
   function automatic logic [DATA_W-1:0] shift_level(
      input logic [DATA_W-1:0] d,
      input logic [2:0]        op,
      input int                n
   );
      logic [DATA_W-1:0]        r;
      logic signed [DATA_W-1:0] ds;
      ds = $signed(d) >>> n;
      if (op[2]) begin
         if (op[1]) r = (d >> n) | (d << (DATA_W - n));
         else       r = (d << n) | (d >> (DATA_W - n));
      end else if (op[1] && op[0]) begin
         r = ds;
      end else if (op[1]) begin
         r = d >> n;
      end else begin
         r = d << n;
      end
      return r;
   endfunction

   // Applies every level that is mapped onto stage s. Level k lives in stage
   // floor(k*PIPE_STAGES/SHAMT_W), which spreads levels as evenly as possible.
   function automatic logic [DATA_W-1:0] stage_shift(
      input int                 s,
      input logic [DATA_W-1:0]  d,
      input logic [SHAMT_W-1:0] shamt,
      input logic [2:0]         op
   );
      logic [DATA_W-1:0] r;
      r = d;
      for (int k = 0; k < SHAMT_W; k++) begin
         if (((k * PIPE_STAGES) / SHAMT_W) == s && shamt[k]) begin
            r = shift_level(r, op, 1 << k);
         end
      end
      return r;
   endfunction

   // Backpressure chain, evaluated from the output stage backwards. A stage
   // moves its contents on when it holds something and the stage after it
   // will be free at the edge; a stage is free when empty or moving on.
   always_comb begin : handshake
      logic downstream_free;
      stage_move      = '0;
      stage_free      = '0;
      downstream_free = out_ready;
      for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
         stage_move[s]   = stage_valid[s] & downstream_free;
         stage_free[s]   = ~stage_valid[s] | stage_move[s];
         downstream_free = stage_free[s];
      end
   end

   assign in_ready = ~flush & stage_free[0];

   // Inputs to each stage register: stage 0 takes the port, later stages take
   // the register in front of them, and each applies its own shift levels.
   always_comb begin
      load_valid    = '0;
      load_valid[0] = in_valid & in_ready;
      next_data[0]  = stage_shift(0, in_data, in_shamt, in_op);
      next_shamt[0] = in_shamt;
      next_op[0]    = in_op;
      next_tag[0]   = in_tag;
      for (int s = 1; s < PIPE_STAGES; s++) begin
         load_valid[s] = stage_move[s-1];
         next_data[s]  = stage_shift(s, stage_data[s-1], stage_shamt[s-1], stage_op[s-1]);
         next_shamt[s] = stage_shamt[s-1];
         next_op[s]    = stage_op[s-1];
         next_tag[s]   = stage_tag[s-1];
      end
   end

   // Stage registers. Valids clear on flush; payload is only captured when a
   // new operation actually enters, so a stalled output stage stays stable.
   // Everything is reset so out_data/out_tag read zero straight after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid <= '0;
         for (int s = 0; s < PIPE_STAGES; s++) begin
            stage_data[s]  <= '0;
            stage_shamt[s] <= '0;
            stage_op[s]    <= '0;
            stage_tag[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            if (flush) begin
               stage_valid[s] <= 1'b0;
            end else if (stage_free[s]) begin
               stage_valid[s] <= load_valid[s];
            end
            if (stage_free[s] && load_valid[s]) begin
               stage_data[s]  <= next_data[s];
               stage_shamt[s] <= next_shamt[s];
               stage_op[s]    <= next_op[s];
               stage_tag[s]   <= next_tag[s];
            end
         end
      end
   end

   assign out_valid = stage_valid[LAST];
   assign out_data  = stage_data[LAST];
   assign out_tag   = stage_tag[LAST];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb_pipe_barrel_shifter
//
// Self-checking bench for pipe_barrel_shifter. Inputs change on the falling
// edge and outputs are sampled 1 ns later, well away from the rising edge.
// Expected results come from a bit-by-bit reference model of the shift ops.
module tb_pipe_barrel_shifter;

   localparam int DATA_W      = 32;
   localparam int SHAMT_W     = $clog2(DATA_W);
   localparam int PIPE_STAGES = 2;
   localparam int TAG_W       = 5;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b010;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b110;

   logic               clk;
   logic               rst_n;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [2:0]         in_op;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic [TAG_W-1:0]   out_tag;

   int checks = 0;
   int errors = 0;

   logic [DATA_W+TAG_W-1:0] exp_q [$];

   pipe_barrel_shifter #(
      .DATA_W      (DATA_W),
      .PIPE_STAGES (PIPE_STAGES),
      .TAG_W       (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the bench can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: defines each result bit from the operand bits directly.
   function automatic logic [DATA_W-1:0] golden(
      input logic [DATA_W-1:0]  d,
      input logic [SHAMT_W-1:0] sh,
      input logic [2:0]         op
   );
      logic [DATA_W-1:0] r;
      int n;
      n = int'(sh);
      for (int i = 0; i < DATA_W; i++) begin
         if (op[2]) begin
            if (op[1]) r[i] = d[(i + n) % DATA_W];
            else       r[i] = d[(i - n + DATA_W) % DATA_W];
         end else if (op[1]) begin
            if (i + n < DATA_W) r[i] = d[i + n];
            else                r[i] = op[0] & d[DATA_W-1];
         end else begin
            if (i >= n) r[i] = d[i - n];
            else        r[i] = 1'b0;
         end
      end
      return r;
   endfunction

   // Idle with the output side draining until the pipeline is empty.
   task automatic drain();
      repeat (PIPE_STAGES + 2) begin
         @(negedge clk);
         in_valid  = 1'b0;
         flush     = 1'b0;
         out_ready = 1'b1;
      end
   endtask

   // Sends one operation into an empty pipeline and reports what comes out
   // and after how many rising edges; lat stays -1 if nothing appears.
   task automatic run_directed(
      input  logic [DATA_W-1:0]  d,
      input  logic [SHAMT_W-1:0] sh,
      input  logic [2:0]         op,
      input  logic [TAG_W-1:0]   tag,
      output logic [DATA_W-1:0]  got_d,
      output logic [TAG_W-1:0]   got_t,
      output int                 lat
   );
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_shamt  = sh;
      in_op     = op;
      in_tag    = tag;
      out_ready = 1'b1;
      got_d     = '0;
      got_t     = '0;
      lat       = -1;
      for (int c = 1; c <= PIPE_STAGES + 8; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         if (out_valid) begin
            lat   = c;
            got_d = out_data;
            got_t = out_tag;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit stale;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_op     = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state: out_valid=%b out_data=%h out_tag=%h, need 0/0/0", out_valid, out_data, out_tag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b, need 1", in_ready);
      end

      // Two ops in flight, output stalled, then reset between clock edges.
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = '0; in_op = OP_SLL; in_tag = 5'h1B;
      out_ready = 1'b0;
      @(negedge clk);
      in_data = 32'h1234_5678; in_tag = 5'h0A;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_tag !== 5'h1B) begin
         errors++;
         $display("[TB] FAIL reset_pre_stall: out_valid=%b data=%h tag=%h, need 1/deadbeef/1b", out_valid, out_data, out_tag);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
         errors++;
         $display("[TB] FAIL reset_async: out_valid=%b out_data=%h out_tag=%h, need 0/0/0", out_valid, out_data, out_tag);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      stale     = 1'b0;
      repeat (PIPE_STAGES + 3) begin
         #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (stale) begin
         errors++;
         $display("[TB] FAIL reset_no_stale: out_valid or in_ready wrong after release, got stale=1, need 0");
      end
   endtask

   task automatic test_ops();
      logic [DATA_W-1:0]  t_data [5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_00F1, 32'h0000_00F1};
      logic [SHAMT_W-1:0] t_sh   [5] = '{5'd4, 5'd4, 5'd31, 5'd4, 5'd4};
      logic [2:0]         t_op   [5] = '{OP_SRA, OP_SRL, OP_SLL, OP_ROR, OP_ROL};
      logic [DATA_W-1:0]  t_exp  [5] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h1000_000F, 32'h0000_0F10};
      logic [DATA_W-1:0]  got_d;
      logic [TAG_W-1:0]   got_t;
      int                 lat;
      drain();
      for (int i = 0; i < 5; i++) begin
         run_directed(t_data[i], t_sh[i], t_op[i], TAG_W'(i + 7), got_d, got_t, lat);
         checks++;
         if (got_d !== t_exp[i] || got_t !== TAG_W'(i + 7) || lat != PIPE_STAGES) begin
            errors++;
            $display("[TB] FAIL ops_%0d: data=%h tag=%h latency=%0d, need %h/%h/%0d",
                     i, got_d, got_t, lat, t_exp[i], TAG_W'(i + 7), PIPE_STAGES);
         end
      end
   endtask

   task automatic test_sh0();
      logic [DATA_W-1:0] got_d;
      logic [TAG_W-1:0]  got_t;
      int                lat;
      drain();
      for (int op = 0; op < 8; op++) begin
         run_directed(32'hA5A5_5A5A, '0, 3'(op), TAG_W'(op * 3 + 1), got_d, got_t, lat);
         checks++;
         if (got_d !== 32'hA5A5_5A5A || got_t !== TAG_W'(op * 3 + 1) || lat != PIPE_STAGES) begin
            errors++;
            $display("[TB] FAIL sh0_op%0d: data=%h tag=%h latency=%0d, need a5a55a5a/%h/%0d",
                     op, got_d, got_t, lat, TAG_W'(op * 3 + 1), PIPE_STAGES);
         end
      end
   endtask

   // Random stream against the scoreboard. With full_rate set, both sides are
   // always willing, so every cycle must accept and the run length is fixed.
   task automatic test_stream(input int n, input int valid_pct, input int ready_pct, input bit full_rate);
      int                      sent;
      int                      got;
      int                      cycles;
      bit                      prev_stall;
      logic [DATA_W-1:0]       prev_data;
      logic [TAG_W-1:0]        prev_tag;
      logic [DATA_W+TAG_W-1:0] exp;
      drain();
      exp_q.delete();
      sent = 0; got = 0; cycles = 0; prev_stall = 1'b0;
      prev_data = '0; prev_tag = '0;
      while ((sent < n || got < n) && cycles < 5000) begin
         @(negedge clk);
         in_valid  = (sent < n) && ($urandom_range(99) < valid_pct);
         in_data   = DATA_W'({$urandom(), $urandom()});
         in_shamt  = SHAMT_W'($urandom_range(DATA_W - 1));
         in_op     = 3'($urandom_range(7));
         in_tag    = TAG_W'($urandom_range((1 << TAG_W) - 1));
         out_ready = ($urandom_range(99) < ready_pct);
         #1;
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag) begin
               errors++;
               $display("[TB] FAIL stream_hold: valid=%b data=%h tag=%h, need 1/%h/%h",
                        out_valid, out_data, out_tag, prev_data, prev_tag);
            end
         end
         if (full_rate && in_valid) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL stream_throughput: in_ready=%b at op %0d, need 1", in_ready, sent);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({golden(in_data, in_shamt, in_op), in_tag});
            sent++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL stream_extra: unexpected result %h tag %h, need none", out_data, out_tag);
            end else begin
               exp = exp_q.pop_front();
               if ({out_data, out_tag} !== exp) begin
                  errors++;
                  $display("[TB] FAIL stream_result_%0d: data=%h tag=%h, need %h/%h",
                           got, out_data, out_tag, exp[DATA_W+TAG_W-1:TAG_W], exp[TAG_W-1:0]);
               end
            end
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_tag   = out_tag;
         cycles++;
      end
      checks++;
      if (sent != n || got != n) begin
         errors++;
         $display("[TB] FAIL stream_count: sent=%0d received=%0d, need %0d/%0d", sent, got, n, n);
      end
      if (full_rate) begin
         checks++;
         if (cycles != n + PIPE_STAGES) begin
            errors++;
            $display("[TB] FAIL stream_cycles: took %0d cycles, need %0d", cycles, n + PIPE_STAGES);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stream_duplicate: out_valid=%b after drain, need 0", out_valid);
      end
   endtask

   task automatic test_flush();
      logic [DATA_W-1:0] got_d;
      logic [TAG_W-1:0]  got_t;
      int                lat;
      bit                leaked;
      drain();
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h0F0F_1234; in_shamt = 5'd3; in_op = OP_SLL; in_tag = 5'h11;
      @(negedge clk);
      in_data = 32'h8765_4321; in_shamt = 5'd9; in_op = OP_SRA; in_tag = 5'h12;
      @(negedge clk);
      flush = 1'b1;
      in_data = 32'hCAFE_F00D; in_shamt = 5'd1; in_op = OP_ROR; in_tag = 5'h13;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_in_ready: got %b during flush, need 0", in_ready);
      end
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_out_valid: got %b after flush, need 0", out_valid);
      end
      leaked = 1'b0;
      repeat (PIPE_STAGES + 2) begin
         @(negedge clk);
         #1;
         if (out_valid !== 1'b0) leaked = 1'b1;
      end
      checks++;
      if (leaked) begin
         errors++;
         $display("[TB] FAIL flush_leak: squashed op emerged, got leak=1, need 0");
      end
      run_directed(32'h1357_9BDF, 5'd12, OP_ROL, 5'h15, got_d, got_t, lat);
      checks++;
      if (got_d !== golden(32'h1357_9BDF, 5'd12, OP_ROL) || got_t !== 5'h15 || lat != PIPE_STAGES) begin
         errors++;
         $display("[TB] FAIL flush_after: data=%h tag=%h latency=%0d, need %h/15/%0d",
                  got_d, got_t, lat, golden(32'h1357_9BDF, 5'd12, OP_ROL), PIPE_STAGES);
      end
   endtask

   // Test sequence.
   initial begin
      test_reset();
      test_ops();
      test_sh0();
      test_stream(20, 100, 100, 1'b1);
      test_stream(100, 80, 50, 1'b0);
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
